// File: rtl/afifo_pkg.sv
// Shared definitions for the async-FIFO read-side packer.
package afifo_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int MAX_RATIO    = 32;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  // Contiguous lane-valid mask with the low cnt bits set.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned cnt);
    logic [MAX_RATIO:0] m;
    m = ((MAX_RATIO+1)'(1) << cnt) - (MAX_RATIO+1)'(1);
    return m[MAX_RATIO-1:0];
  endfunction

endpackage

// File: rtl/pack_out_slot.sv
// Valid/ready output register: loads a packed word, holds it under backpressure,
// drains on accept.
module pack_out_slot #(
  parameter int W  = 32,
  parameter int KW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [W-1:0]  data_i,
  input  logic [KW-1:0] keep_i,
  input  logic          ready_i,
  output logic          free_o,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [KW-1:0] keep_o
);

  logic          valid_q;
  logic [W-1:0]  data_q;
  logic [KW-1:0] keep_q;

  assign free_o = ~valid_q | ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;

endmodule

// File: rtl/afifo_rd_packer.sv
// Pops entries from the async FIFO read port and packs RATIO of them into one
// wide word; partial words leave on idle timeout or flush.
module afifo_rd_packer
  import afifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int RATIO    = 4,
  parameter int TIMEOUT  = 16,
  parameter int WARMUP   = 2
) (
  input  logic                      rclk,
  input  logic                      rrst,
  input  logic                      rempty,
  input  logic [DATASIZE-1:0]       rdata,
  output logic                      rinc,
  input  logic                      flush,
  output logic [DATASIZE*RATIO-1:0] m_data,
  output logic [RATIO-1:0]          m_keep,
  output logic                      m_valid,
  input  logic                      m_ready
);

  localparam int CW = $clog2(RATIO+1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  localparam int WW = (WARMUP  > 0) ? $clog2(WARMUP+1)  : 1;
  localparam state_e ST_RST = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_e                           state_q, state_d;
  logic [WW-1:0]                    wcnt_q, wcnt_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [RATIO-1:0][DATASIZE-1:0]   acc_q, acc_d;
  logic [IW-1:0]                    idle_q, idle_d;
  logic                             fpend_q, fpend_d;

  logic                             full, nz, timeout, free, xfer, pop;
  logic [RATIO-1:0]                 keep_w;
  logic [RATIO-1:0][DATASIZE-1:0]   word_w;

  // rempty is not trusted right after reset, so popping waits for RUN.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_WARMUP: begin
        if (wcnt_q != '0) wcnt_d = wcnt_q - WW'(1);
        if (wcnt_q <= WW'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign full    = (cnt_q == CW'(RATIO));
  assign nz      = (cnt_q != '0);
  assign timeout = (TIMEOUT != 0) && (idle_q == IW'(TIMEOUT));
  assign xfer    = free & (full | (nz & (timeout | flush | fpend_q)));
  // m_ready reaches rinc through free/xfer so a full accumulator can refill
  // in the same cycle it drains.
  assign pop     = (state_q == ST_RUN) & ~rempty & (~full | xfer);
  assign rinc    = pop;

  assign keep_w  = RATIO'(keep_mask(32'(cnt_q)));

  always_comb begin
    word_w = '0;
    for (int i = 0; i < RATIO; i++)
      if (keep_w[i]) word_w[i] = acc_q[i];
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (pop) begin
      if (xfer) begin
        acc_d[0] = rdata;
        cnt_d    = CW'(1);
      end else begin
        for (int i = 0; i < RATIO; i++)
          if (cnt_q == CW'(i)) acc_d[i] = rdata;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (xfer) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (pop | xfer | ~nz)             idle_d = '0;
    else if (idle_q != IW'(TIMEOUT))  idle_d = idle_q + IW'(1);
    fpend_d = xfer ? 1'b0 : (fpend_q | (flush & nz & ~free));
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= ST_RST;
      wcnt_q  <= WW'(WARMUP);
      cnt_q   <= '0;
      acc_q   <= '0;
      idle_q  <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idle_q  <= idle_d;
      fpend_q <= fpend_d;
    end
  end

  pack_out_slot #(.W(DATASIZE*RATIO), .KW(RATIO)) u_slot (
    .clk_i   (rclk),
    .rst_i   (rrst),
    .load_i  (xfer),
    .data_i  (word_w),
    .keep_i  (keep_w),
    .ready_i (m_ready),
    .free_o  (free),
    .valid_o (m_valid),
    .data_o  (m_data),
    .keep_o  (m_keep)
  );

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Directed bench for afifo_rd_packer with a behavioural FIFO read port.
module tb_afifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst, rempty, rinc, flush, m_valid, m_ready;
  logic [7:0]  rdata;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  logic [7:0]  mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;

  int checks = 0;
  int errors = 0;
  int n;

  assign rempty = (wr_ptr == rd_ptr);
  assign rdata  = mem[rd_ptr];

  always #5 rclk = ~rclk;

  always @(posedge rclk)
    if (rinc && !rempty) rd_ptr <= rd_ptr + 8'd1;

  afifo_rd_packer dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .flush   (flush),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_valid(input string tag, input int maxc, output int cyc);
    cyc = 0;
    while (m_valid !== 1'b1 && cyc < maxc) begin
      @(negedge rclk);
      cyc++;
    end
    chk({tag, " valid"}, m_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rrst = 1'b1; flush = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i * 17));

    // Reset and warm-up with a non-empty FIFO
    repeat (3) @(negedge rclk);
    chk("reset rinc",    rinc,    0);
    chk("reset m_valid", m_valid, 0);
    chk("reset m_keep",  m_keep,  0);
    chk("reset m_data",  m_data,  0);
    rrst = 1'b0;
    @(negedge rclk); chk("warmup cycle2 rinc", rinc, 0);
    @(negedge rclk); chk("warmup cycle3 rinc", rinc, 1);

    // Streaming: one full word every 4 cycles
    wait_valid("stream w1", 20, n);
    chk("stream w1 data", m_data, 32'h44332211);
    chk("stream w1 keep", m_keep, 4'hF);
    n = 0;
    do begin @(negedge rclk); n++; end while (m_valid !== 1'b1 && n < 12);
    chk("stream spacing", n, 4);
    chk("stream w2 data", m_data, 32'h88776655);
    @(negedge rclk); chk("stream drained", m_valid, 0);

    // Backpressure: word 1 held, word 2 accumulated, FIFO backs up
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push(8'(i));
    wait_valid("bp w1", 20, n);
    chk("bp w1 data", m_data, 32'h04030201);
    repeat (8) @(negedge rclk);
    chk("bp hold valid", m_valid, 1);
    chk("bp hold data",  m_data,  32'h04030201);
    chk("bp fifo nonempty", rempty, 0);
    chk("bp full rinc",  rinc,    0);
    m_ready = 1'b1;
    @(negedge rclk);
    chk("bp w2 valid", m_valid, 1);
    chk("bp w2 data",  m_data,  32'h08070605);
    chk("bp w2 keep",  m_keep,  4'hF);
    @(negedge rclk); chk("bp drained", m_valid, 0);
    wait_valid("single timeout", 30, n);
    chk("single timeout cycles", n, 16);
    chk("single timeout data", m_data, 32'h00000009);
    chk("single timeout keep", m_keep, 4'b0001);
    @(negedge rclk);

    // Idle timeout on a two-entry partial word
    push(8'hA1); push(8'hB2);
    wait_valid("timeout", 40, n);
    chk("timeout cycles", n, 19);
    chk("timeout data", m_data, 32'h0000B2A1);
    chk("timeout keep", m_keep, 4'b0011);
    @(negedge rclk); chk("timeout drained", m_valid, 0);

    // Flush: ignored when empty, deferred while the slot is busy
    flush = 1'b1;
    @(negedge rclk); flush = 1'b0;
    repeat (3) @(negedge rclk);
    chk("flush empty ignored", m_valid, 0);
    m_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    push(8'hD1); push(8'hD2); push(8'hD3);
    repeat (8) @(negedge rclk);
    chk("flush busy valid", m_valid, 1);
    chk("flush busy data",  m_data,  32'hC4C3C2C1);
    flush = 1'b1;
    @(negedge rclk); flush = 1'b0;
    chk("flush pend hold", m_data, 32'hC4C3C2C1);
    m_ready = 1'b1;
    @(negedge rclk);
    chk("flush emit valid", m_valid, 1);
    chk("flush emit data",  m_data,  32'h00D3D2D1);
    chk("flush emit keep",  m_keep,  4'b0111);
    @(negedge rclk); chk("flush single emit", m_valid, 0);

    // Reset mid-word discards popped entries
    push(8'hE1); push(8'hE2);
    repeat (3) @(negedge rclk);
    rrst = 1'b1;
    @(negedge rclk); rrst = 1'b0;
    chk("midrst m_valid", m_valid, 0);
    chk("midrst m_keep",  m_keep,  0);
    chk("midrst m_data",  m_data,  0);
    push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
    @(negedge rclk); chk("midrst warmup rinc", rinc, 0);
    wait_valid("midrst word", 20, n);
    chk("midrst word data", m_data, 32'hF4F3F2F1);
    chk("midrst word keep", m_keep, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
